// File: rtl/mrd_fsmsink_p4_pkg.sv
// rtl/mrd_fsmsink_p4_pkg.sv - shared constants and state type for the p4 input sink
// Holds the sample/address geometry, the top-FSM Sink code and the local
// sink state enumeration used by mrd_fsmsink_p4 and its helpers.
package mrd_fsmsink_p4_pkg;

  localparam int W_DATA = 16;               // real / imaginary part width
  localparam int W_ADDR = 10;               // per-bank address width
  localparam int NBANK  = 4;                // banks, fixed for the p4 datapath
  localparam int W_CNT  = W_ADDR + 2;       // sample index width (4096 samples)

  localparam logic [2:0] FSM_SINK = 3'd1;   // top FSM state code for Sink

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOP = 2'd1,
    ST_RECV     = 2'd2,
    ST_DONE     = 2'd3
  } sink_state_e;

endpackage

// File: rtl/mrd_fsmsink_p4_if.sv
// rtl/mrd_fsmsink_p4_if.sv - sop/eop/valid/ready sample stream into the sink
// Signals: in_valid, in_sop, in_eop, in_real, in_imag (source -> sink),
//          in_ready (sink -> source).
// master: the upstream sample source; slave: the sink stage.
interface mrd_fsmsink_p4_if;
  import mrd_fsmsink_p4_pkg::*;

  logic              in_valid;
  logic              in_sop;
  logic              in_eop;
  logic [W_DATA-1:0] in_real;
  logic [W_DATA-1:0] in_imag;
  logic              in_ready;

  modport master (
    output in_valid, in_sop, in_eop, in_real, in_imag,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_real, in_imag,
    output in_ready
  );

endinterface

// File: rtl/mrd_fsmsink_p4_addr_gen.sv
// rtl/mrd_fsmsink_p4_addr_gen.sv - sample index to bank/address map with write register
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   we                  write this cycle's sample
//   idx                 natural-order sample index
//   din_real, din_imag  sample to store
//   wren                one-hot bank enable (bank = idx[1:0]), registered
//   wraddr              bank address (idx[11:2]), registered
//   wrdata_real/imag    registered write data
module mrd_fsmsink_p4_addr_gen
  import mrd_fsmsink_p4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [W_CNT-1:0]  idx,
  input  logic [W_DATA-1:0] din_real,
  input  logic [W_DATA-1:0] din_imag,
  output logic [NBANK-1:0]  wren,
  output logic [W_ADDR-1:0] wraddr,
  output logic [W_DATA-1:0] wrdata_real,
  output logic [W_DATA-1:0] wrdata_imag
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wren        <= '0;
      wraddr      <= '0;
      wrdata_real <= '0;
      wrdata_imag <= '0;
    end else begin
      // Enable is a single-cycle strobe; address/data just hold between writes.
      wren <= we ? (NBANK'(1) << idx[1:0]) : '0;
      if (we) begin
        wraddr      <= idx[W_CNT-1:2];
        wrdata_real <= din_real;
        wrdata_imag <= din_imag;
      end
    end
  end

endmodule

// File: rtl/mrd_fsmsink_p4.sv
// rtl/mrd_fsmsink_p4.sv - input sink: stores one frame of samples into 4 banks
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fsm                 top FSM state (Sink = 3'd1)
//   dftpts              frame length, captured on each accepted sop (0 = 4096)
//   in_if               sample stream (slave side), in_ready combinational
//   wren                one-hot bank write enable, 1 cycle after the beat
//   wraddr              shared bank write address
//   wrdata_real/imag    write data
//   sink_end            pulse: frame closed and stored
//   sink_err            pulse: framing error (early/missing eop, re-sop, abort)
module mrd_fsmsink_p4
  import mrd_fsmsink_p4_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        fsm,
  input  logic [W_CNT-1:0]  dftpts,
  mrd_fsmsink_p4_if.slave   in_if,
  output logic [NBANK-1:0]  wren,
  output logic [W_ADDR-1:0] wraddr,
  output logic [W_DATA-1:0] wrdata_real,
  output logic [W_DATA-1:0] wrdata_imag,
  output logic              sink_end,
  output logic              sink_err
);

  sink_state_e      state_q, state_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic [W_CNT-1:0] len_q, len_d;

  logic             in_sink;
  logic             accept;
  logic             restart;
  logic [W_CNT-1:0] len_sel;
  logic [W_CNT-1:0] k;
  logic             is_last;
  logic             frame_close;
  logic             bad_close;
  logic             we;
  logic             end_d;
  logic             err_d;

  assign in_sink         = (fsm == FSM_SINK);
  assign in_if.in_ready  = (state_q == ST_WAIT_SOP) || (state_q == ST_RECV);
  assign accept          = in_if.in_valid & in_if.in_ready;
  assign restart         = accept & in_if.in_sop;

  // A sop beat is always index 0 of a frame whose length is the live dftpts.
  // len-1 is taken modulo 4096, so a stored length of 0 closes at 4095.
  assign len_sel     = restart ? dftpts : len_q;
  assign k           = restart ? '0 : cnt_q;
  assign is_last     = (k == (len_sel - W_CNT'(1)));
  assign frame_close = in_if.in_eop | is_last;
  assign bad_close   = ~(in_if.in_eop & is_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    we      = 1'b0;
    end_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_sink) state_d = ST_WAIT_SOP;
      end
      ST_WAIT_SOP: begin
        // Leaving Sink before any frame started is not an error.
        if (!in_sink) begin
          state_d = ST_IDLE;
        end else if (restart) begin
          we      = 1'b1;
          len_d   = dftpts;
          cnt_d   = W_CNT'(1);
          state_d = ST_RECV;
          if (frame_close) begin
            state_d = ST_DONE;
            end_d   = 1'b1;
            err_d   = bad_close;
          end
        end
      end
      ST_RECV: begin
        if (!in_sink) begin
          // Abandoned frame: flag it, but never claim it was stored.
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (accept) begin
          we    = 1'b1;
          cnt_d = restart ? W_CNT'(1) : cnt_q + W_CNT'(1);
          if (restart) begin
            len_d = dftpts;
            err_d = 1'b1;
          end
          if (frame_close) begin
            state_d = ST_DONE;
            end_d   = 1'b1;
            if (bad_close) err_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (!in_sink) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sink_end <= 1'b0;
      sink_err <= 1'b0;
    end else begin
      // end can only fire on entry to DONE, so it never repeats back to back.
      // Back-to-back errors (e.g. re-sop then early eop) merge into one pulse.
      sink_end <= end_d;
      sink_err <= err_d & ~sink_err;
    end
  end

  mrd_fsmsink_p4_addr_gen u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (we),
    .idx         (k),
    .din_real    (in_if.in_real),
    .din_imag    (in_if.in_imag),
    .wren        (wren),
    .wraddr      (wraddr),
    .wrdata_real (wrdata_real),
    .wrdata_imag (wrdata_imag)
  );

endmodule

// File: tb/tb_mrd_fsmsink_p4.sv
// tb/tb_mrd_fsmsink_p4.sv - self-checking bench for mrd_fsmsink_p4
module tb_mrd_fsmsink_p4;
  import mrd_fsmsink_p4_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2:0]        fsm;
  logic [W_CNT-1:0]  dftpts;
  logic [NBANK-1:0]  wren;
  logic [W_ADDR-1:0] wraddr;
  logic [W_DATA-1:0] wr_re, wr_im;
  logic              sink_end, sink_err;

  mrd_fsmsink_p4_if bus ();

  mrd_fsmsink_p4 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fsm         (fsm),
    .dftpts      (dftpts),
    .in_if       (bus),
    .wren        (wren),
    .wraddr      (wraddr),
    .wrdata_real (wr_re),
    .wrdata_imag (wr_im),
    .sink_end    (sink_end),
    .sink_err    (sink_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [3:0]  wren;
    logic [9:0]  addr;
    logic [15:0] re;
    logic [15:0] im;
  } wr_t;

  wr_t exp_q[$];
  int  obs_end[$], obs_err[$], exp_end[$], exp_err[$];
  int  nchecks = 0, nfail = 0, nwr = 0;
  int  last_wraddr = 0;
  bit  chk_en = 1'b0;
  bit  prev_end = 1'b0, prev_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] d_re(input int b);
    return 16'(32'h1000 + b * 7);
  endfunction

  function automatic logic [15:0] d_im(input int b);
    return 16'(32'hA5A5 ^ b);
  endfunction

  // Per-cycle compare: writes against the expected-write scoreboard, pulses logged.
  always @(negedge clk) begin : cmp
    wr_t e;
    if (chk_en) begin
      if (wren != 4'd0) begin
        nwr++;
        last_wraddr = int'(wraddr);
        if (exp_q.size() == 0) begin
          check("unexpected_wr", 32'(wren), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_cyc", cyc, e.cyc);
          check("wren", 32'(wren), 32'(e.wren));
          check("wraddr", 32'(wraddr), 32'(e.addr));
          check("wr_re", 32'(wr_re), 32'(e.re));
          check("wr_im", 32'(wr_im), 32'(e.im));
        end
      end
      if (sink_end) obs_end.push_back(cyc);
      if (sink_err) obs_err.push_back(cyc);
      check("pulse_gap", {30'd0, sink_end & prev_end, sink_err & prev_err}, 32'd0);
      prev_end = sink_end;
      prev_err = sink_err;
    end
  end

  task automatic idle_bus();
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  task automatic start_sink(input int dft);
    int n;
    idle_bus();
    fsm = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete(); obs_end.delete(); obs_err.delete();
    exp_end.delete(); exp_err.delete();
    nwr = 0;
    fsm = FSM_SINK;
    dftpts = W_CNT'(dft);
    n = 0;
    while (!bus.in_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait", 32'(bus.in_ready), 32'd1);
  endtask

  // Expected writes derived from the frame rules: sample index -> bank idx%4, addr idx/4.
  task automatic push_write(input int c, input int idx, input int b);
    wr_t e;
    e.cyc  = c;
    e.wren = 4'(1 << (idx % 4));
    e.addr = 10'(idx / 4);
    e.re   = d_re(b);
    e.im   = d_im(b);
    exp_q.push_back(e);
  endtask

  task automatic compare_pulses();
    check("wq_empty", exp_q.size(), 0);
    check("end_count", obs_end.size(), exp_end.size());
    for (int i = 0; i < obs_end.size() && i < exp_end.size(); i++)
      check("end_cyc", obs_end[i], exp_end[i]);
    check("err_count", obs_err.size(), exp_err.size());
    for (int i = 0; i < obs_err.size() && i < exp_err.size(); i++)
      check("err_cyc", obs_err[i], exp_err[i]);
  endtask

  // Drives one frame: sop at beat 0 (and resop_at), eop at eop_at (-1: none).
  task automatic run_frame(input int dft, input int nbeats, input int eop_at,
                           input int resop_at, input bit gapped);
    int L, start, last_b, close, step, c0, idx;
    bit end_err;
    start_sink(dft);
    L      = (dft == 0) ? 4096 : dft;
    start  = (resop_at >= 0) ? resop_at : 0;
    last_b = start + L - 1;
    close  = (eop_at >= start && eop_at < last_b) ? eop_at : last_b;
    step   = gapped ? 2 : 1;
    c0     = cyc;
    for (int b = 0; b <= close && b < nbeats; b++) begin
      idx = (b < start) ? b : b - start;
      push_write(c0 + b * step + 1, idx, b);
    end
    if (resop_at >= 0) exp_err.push_back(c0 + resop_at * step + 1);
    end_err = !(eop_at == close && close == last_b);
    if (close < nbeats) begin
      exp_end.push_back(c0 + close * step + 1);
      if (end_err) exp_err.push_back(c0 + close * step + 1);
    end
    for (int b = 0; b < nbeats; b++) begin
      bus.in_valid = 1'b1;
      bus.in_sop   = (b == 0) || (b == resop_at);
      bus.in_eop   = (b == eop_at);
      bus.in_real  = d_re(b);
      bus.in_imag  = d_im(b);
      @(posedge clk); #1;
      if (gapped) begin
        idle_bus();
        bus.in_real = 16'hDEAD;
        @(posedge clk); #1;
      end
    end
    idle_bus();
    repeat (3) @(posedge clk);
    #1;
    compare_pulses();
  endtask

  initial begin
    int c;
    fsm = 3'd0;
    dftpts = '0;
    bus.in_real = '0;
    bus.in_imag = '0;
    idle_bus();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.in_ready), 32'd0);
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_wraddr", 32'(wraddr), 32'd0);
    check("rst_wrdata", {wr_re, wr_im}, 32'd0);
    check("rst_pulses", {30'd0, sink_end, sink_err}, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Normal frame of 12
    run_frame(12, 12, 11, -1, 1'b0);
    check("norm_nwr", nwr, 12);
    check("norm_last_addr", last_wraddr, 2);
    check("norm_no_err", obs_err.size(), 0);

    // Gapped 48-sample frame
    run_frame(48, 48, 47, -1, 1'b1);
    check("gap_nwr", nwr, 48);
    check("gap_last_addr", last_wraddr, 11);

    // Early eop on beat 9 of 24
    run_frame(24, 10, 9, -1, 1'b0);
    check("early_nwr", nwr, 10);
    check("early_err_cnt", obs_err.size(), 1);
    check("early_ready", 32'(bus.in_ready), 32'd0);

    // Missing eop: 16 beats, 12-sample frame
    run_frame(12, 16, -1, -1, 1'b0);
    check("miss_nwr", nwr, 12);
    check("miss_end_cnt", obs_end.size(), 1);

    // Re-sop at beat 5, frame closes 12 beats later
    run_frame(12, 17, 16, 5, 1'b0);
    check("resop_nwr", nwr, 17);
    check("resop_err_cnt", obs_err.size(), 1);

    // sop+eop on one beat: legal only for a 1-sample frame
    run_frame(1, 1, 0, -1, 1'b0);
    check("one_err", obs_err.size(), 0);
    run_frame(12, 1, 0, -1, 1'b0);
    check("sopeop_err", obs_err.size(), 1);

    // dftpts = 0 means 4096 samples
    run_frame(0, 4096, 4095, -1, 1'b0);
    check("full_nwr", nwr, 4096);
    check("full_last_addr", last_wraddr, 1023);

    // Abort: fsm leaves Sink mid-frame
    start_sink(24);
    c = cyc;
    for (int b = 0; b < 6; b++) push_write(c + b + 1, b, b);
    for (int b = 0; b < 6; b++) begin
      bus.in_valid = 1'b1;
      bus.in_sop   = (b == 0);
      bus.in_eop   = 1'b0;
      bus.in_real  = d_re(b);
      bus.in_imag  = d_im(b);
      @(posedge clk); #1;
    end
    idle_bus();
    fsm = 3'd0;
    exp_err.push_back(cyc + 1);
    @(posedge clk); #1;
    check("abort_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    compare_pulses();
    check("abort_nwr", nwr, 6);

    // Asynchronous reset mid-frame
    start_sink(12);
    c = cyc;
    for (int b = 0; b < 8; b++) push_write(c + b + 1, b, b);
    for (int b = 0; b < 8; b++) begin
      bus.in_valid = 1'b1;
      bus.in_sop   = (b == 0);
      bus.in_eop   = 1'b0;
      bus.in_real  = d_re(b);
      bus.in_imag  = d_im(b);
      @(posedge clk); #1;
    end
    idle_bus();
    @(posedge clk); #1;
    check("pre_rst_addr", 32'(wraddr), 32'd1);
    check("pre_rst_ready", 32'(bus.in_ready), 32'd1);
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(bus.in_ready), 32'd0);
    check("arst_wren", 32'(wren), 32'd0);
    check("arst_wraddr", 32'(wraddr), 32'd0);
    check("arst_wrdata", {wr_re, wr_im}, 32'd0);
    check("arst_pulses", {30'd0, sink_end, sink_err}, 32'd0);
    check("arst_nwr", nwr, 8);
    check("arst_wq", exp_q.size(), 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_idle", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    check("post_rst_wait", 32'(bus.in_ready), 32'd1);
    prev_end = 1'b0;
    prev_err = 1'b0;
    chk_en = 1'b1;

    run_frame(16, 16, 15, -1, 1'b0);
    check("after_rst_nwr", nwr, 16);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
